// File: rtl/ksynth_frame_pkg.sv
// Shared definitions for the byte frame loader: parser state encoding,
// default sync marker and payload bank geometry.
package ksynth_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CKSUM = 2'd2
    } frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         NBYTES       = 4;
    localparam int         IDX_W        = 2;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/frame_byte_bank.sv
// Shadow/active payload banks with an atomic commit and a registered byte
// read port. A commit may coincide with the write of the last shadow byte.
module frame_byte_bank
    import ksynth_frame_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       we,
    input  idx_t       wr_idx,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       flush,
    input  logic [1:0] rd_adr,
    output logic [7:0] rd_data
);

    logic [7:0] shadow [NBYTES];
    logic [7:0] active [NBYTES];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NBYTES; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
            rd_data <= 8'h00;
        end else begin
            if (flush) begin
                for (int i = 0; i < NBYTES; i++) shadow[i] <= 8'h00;
            end else if (we) begin
                shadow[wr_idx] <= wr_data;
            end
            // The byte being written this cycle bypasses the shadow so a
            // frame ending on a payload byte commits in the same cycle.
            if (commit) begin
                for (int i = 0; i < NBYTES; i++)
                    active[i] <= (we && wr_idx == idx_t'(i)) ? wr_data : shadow[i];
            end
            rd_data <= active[rd_adr];
        end
    end

endmodule

// File: rtl/byte_frame_loader.sv
// Serial frame parser (sync, 4 payload bytes, optional checksum) feeding a
// banked byte read port. Checksum stage is enabled by BYTE_FRAME_CKSUM_EN.
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; every
// strobed byte is consumed in the cycle it is presented.
module byte_frame_loader
    import ksynth_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         TIMEOUT   = 50000,
    parameter int         TMR_W     = 20
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic [1:0]   rd_adr,
    output logic [7:0]   rd_data,
    output logic         frame_ok,
    output logic         frame_err,
    output logic         busy,
    output frame_state_t dbg_state
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);
    localparam idx_t             IDX_LAST = idx_t'(NBYTES - 1);

    frame_state_t     state, state_next;
    idx_t             idx;
    logic [TMR_W-1:0] timer;
`ifdef BYTE_FRAME_CKSUM_EN
    logic [7:0]       sum;
`endif

    logic start, bank_we, commit, flush, ok_next, err_next, expire;

    // Expiry fires on the idle cycle whose increment would bring the
    // timer to TIMEOUT-1; a byte in that cycle takes priority.
    assign expire = (state != IDLE) && !rx_valid && (timer == TMR_LAST);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        bank_we    = 1'b0;
        commit     = 1'b0;
        flush      = 1'b0;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    start      = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    bank_we = 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef BYTE_FRAME_CKSUM_EN
                        state_next = CKSUM;
`else
                        commit     = 1'b1;
                        ok_next    = 1'b1;
                        state_next = IDLE;
`endif
                    end
                end else if (expire) begin
                    err_next   = 1'b1;
                    flush      = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef BYTE_FRAME_CKSUM_EN
            CKSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum) begin
                        commit  = 1'b1;
                        ok_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = IDLE;
                end else if (expire) begin
                    err_next   = 1'b1;
                    flush      = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_ok  <= ok_next;
            frame_err <= err_next;
            if (start)        idx <= '0;
            else if (bank_we) idx <= idx + idx_t'(1);
            if (state == IDLE || rx_valid || expire) timer <= '0;
            else                                     timer <= timer + TMR_W'(1);
        end
    end

`ifdef BYTE_FRAME_CKSUM_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                             sum <= 8'h00;
        else if (start)                      sum <= 8'h00;
        else if (bank_we && state == DATA)   sum <= sum + rx_data;
    end
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    frame_byte_bank u_bank (
        .clk     (clk),
        .clr     (clr),
        .we      (bank_we),
        .wr_idx  (idx),
        .wr_data (rx_data),
        .commit  (commit),
        .flush   (flush),
        .rd_adr  (rd_adr),
        .rd_data (rd_data)
    );

endmodule
